to_proj: RTL and testbench
==========================

TO_PROJ -- requirements
Module: to_proj

Interface
REQ-001 Parameter N, default 255: operand and result width in bits; the arithmetic is defined for N=255 only.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-high reset; the port name is kept for codebase compatibility and the polarity is high-true.
REQ-004 en  input  1  start strobe; sampled on the rising edge only while IDLE.
REQ-005 Px  input  N  affine x coordinate.
REQ-006 Py  input  N  affine y coordinate.
REQ-007 Rx  output  N  extended X = Px mod p, registered.
REQ-008 Ry  output  N  extended Y = Py mod p, registered.
REQ-009 Rz  output  N  extended Z = 1, registered.
REQ-010 Rt  output  N  extended T = Px*Py mod p, registered.

Function
REQ-011 The field prime SHALL be p = 2^255 - 19, and every output SHALL be fully reduced to the range [0, p-1].
REQ-012 The block SHALL use three states, IDLE, MUL and DONE, and SHALL power up and reset into IDLE.
REQ-013 In IDLE with en=1 at an edge, the block SHALL latch Px and Py, clear the accumulator, set the bit index to 254 and enter MUL; with en=0 it SHALL remain in IDLE.
REQ-014 On latch, each operand SHALL be reduced by one conditional subtraction: if the value is >= p, p is subtracted; one subtraction is sufficient because 2^255-1 < 2p.
REQ-015 MUL SHALL compute the product by MSB-first interleaved modular multiplication, one bit of reduced Py per cycle:
- acc = 2*acc, minus p if the result is >= p;
- then, if the Py bit is set, acc = acc + x, minus p if the result is >= p.
REQ-016 Internal adders and comparators SHALL be 256 bits wide so that 2*acc and acc+x cannot overflow.
REQ-017 After the bit-0 iteration (255 MUL cycles), the block SHALL enter DONE.
REQ-018 DONE SHALL write Rx=x, Ry=y, Rz=1 and Rt=acc in the same edge and return to IDLE.
REQ-019 Latency: outputs SHALL update exactly 257 rising edges after the edge that sampled en=1, namely 1 latch edge + 255 MUL edges + 1 DONE edge.
REQ-020 All four outputs SHALL change only in DONE and SHALL hold their previous values while a computation is in progress.
REQ-021 en asserted in MUL or DONE SHALL be ignored.
REQ-022 en held high continuously SHALL start a new computation on the first edge in IDLE after DONE.
REQ-023 Changes to Px and Py after the latch edge SHALL have no effect on the running computation.
REQ-024 No done or busy port is provided; the consumer relies on the fixed latency in REQ-019.

Reset
REQ-025 While rst_n=1, the block SHALL immediately, without waiting for a clock edge, force state=IDLE, accumulator=0, latched operands=0 and Rx=Ry=Rz=Rt=0.
REQ-026 A reset asserted mid-computation SHALL abort the computation; no partial result may ever appear on the outputs.
REQ-027 After reset is released, the block SHALL wait in IDLE for en.

Verification
REQ-028 Reset: assert rst_n=1 -> Rx=Ry=Rz=Rt=0; hold them for 300 cycles with en=0 -> outputs still 0.
REQ-029 Neutral point: Px=0, Py=1, en pulse for 1 cycle -> 257 edges later (Rx,Ry,Rz,Rt) = (0,1,1,0), stable until the next start.
REQ-030 Small values and wrap: (2,3) -> (2,3,1,6); (2^254, 2) -> (2^254, 2, 1, 19), since 2^255 mod p = 19.
REQ-031 Boundary: (p-1, p-1) -> (p-1, p-1, 1, 1); unreduced input (p, 5) -> (0, 5, 1, 0).
REQ-032 Robustness, three checks:
- en pulses during MUL are ignored; the result is unchanged and latency is still 257 edges;
- Px/Py changed mid-operation do not affect the result;
- rst_n=1 at cycle 100 of an operation -> outputs 0 immediately and nothing is written later.

Source files
------------

// File: rtl/to_proj.sv
// Affine-to-extended projective conversion over GF(2^255-19): (X,Y,Z,T) = (x, y, 1, x*y mod p).
// Uses a bit-serial MSB-first interleaved modular multiplier, with fixed latency and no handshake.
module to_proj #(
    parameter int N = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] Px,
    input  logic [N-1:0] Py,
    output logic [N-1:0] Rx,
    output logic [N-1:0] Ry,
    output logic [N-1:0] Rz,
    output logic [N-1:0] Rt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [N:0] P =
        256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

    // Inputs are below 2^255, which is less than 2p, so a single conditional subtract reduces fully.
    function automatic logic [N-1:0] mod_reduce(input logic [N:0] v);
        logic [N:0] r;
        if (v >= P) begin
            r = v - P;
        end else begin
            r = v;
        end
        return r[N-1:0];
    endfunction

    state_e       state_q, state_d;
    logic [N-1:0] acc_q, acc_d;
    logic [N-1:0] x_q, x_d;
    logic [N-1:0] y_q, y_d;
    logic [7:0]   idx_q, idx_d;
    logic [N-1:0] rx_q, rx_d, ry_q, ry_d, rz_q, rz_d, rt_q, rt_d;
    logic [N-1:0] step_s;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            idx_q   <= 8'd0;
            rx_q    <= '0;
            ry_q    <= '0;
            rz_q    <= '0;
            rt_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            y_q     <= y_d;
            idx_q   <= idx_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
            rz_q    <= rz_d;
            rt_q    <= rt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = MUL;
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                if (idx_q == 8'd0) begin
                    state_d = DONE;
                end else begin
                    state_d = MUL;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One multiplier iteration: doubling, then a conditional addition of x, each followed by a reduction.
    always_comb begin
        logic [N:0] dbl;
        logic [N:0] sum;
        dbl = mod_reduce({acc_q, 1'b0}) ;
        if (y_q[idx_q]) begin
            sum    = {1'b0, dbl[N-1:0]} + {1'b0, x_q};
            step_s = mod_reduce(sum);
        end else begin
            sum    = '0;
            step_s = dbl[N-1:0];
        end
    end

    always_comb begin
        acc_d = acc_q;
        x_d   = x_q;
        y_d   = y_q;
        idx_d = idx_q;
        rx_d  = rx_q;
        ry_d  = ry_q;
        rz_d  = rz_q;
        rt_d  = rt_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    x_d   = mod_reduce({1'b0, Px});
                    y_d   = mod_reduce({1'b0, Py});
                    acc_d = '0;
                    idx_d = 8'd254;
                end else begin
                    acc_d = acc_q;
                end
            end
            MUL: begin
                acc_d = step_s;
                if (idx_q != 8'd0) begin
                    idx_d = idx_q - 8'd1;
                end else begin
                    idx_d = 8'd0;
                end
            end
            DONE: begin
                rx_d = x_q;
                ry_d = y_q;
                rz_d = {{(N-1){1'b0}}, 1'b1};
                rt_d = acc_q;
            end
            default: begin
                acc_d = '0;
            end
        endcase
    end

    assign Rx = rx_q;
    assign Ry = ry_q;
    assign Rz = rz_q;
    assign Rt = rt_q;

endmodule

// File: tb/tb_to_proj.sv
// Self-checking bench for to_proj, comparing against a wide-integer model of (x mod p, y mod p, 1, x*y mod p).
module tb_to_proj;

    localparam int N = 255;
    localparam logic [511:0] P512 = {256'd0,
        256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed};

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [N-1:0] Px, Py;
    logic [N-1:0] Rx, Ry, Rz, Rt;

    int total_cnt  = 0;
    int passed_cnt = 0;

    logic [N-1:0] prev_x, prev_y, prev_z, prev_t;
    logic [N-1:0] p_val, p_m1;

    to_proj #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .Px(Px), .Py(Py), .Rx(Rx), .Ry(Ry), .Rz(Rz), .Rt(Rt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0] ref_mod(input logic [N-1:0] a);
        logic [511:0] w;
        w = {257'd0, a} % P512;
        return w[N-1:0];
    endfunction

    function automatic logic [N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [511:0] w;
        w = ({257'd0, a} * {257'd0, b}) % P512;
        return w[N-1:0];
    endfunction

    function automatic logic [N-1:0] rand_val();
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r = {r[223:0], 32'($urandom())};
        return r[N-1:0];
    endfunction

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        total_cnt++;
        assert (obs === exp) passed_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag, input logic [N-1:0] ex, input logic [N-1:0] ey,
                             input logic [N-1:0] ez, input logic [N-1:0] et);
        check({tag, ".Rx"}, Rx, ex);
        check({tag, ".Ry"}, Ry, ey);
        check({tag, ".Rz"}, Rz, ez);
        check({tag, ".Rt"}, Rt, et);
    endtask

    // Start one conversion, scramble inputs after the latch edge, optionally pulse en while busy.
    task automatic run(input string tag, input logic [N-1:0] px, input logic [N-1:0] py,
                       input bit pulse_en);
        logic [N-1:0] ex, ey, et;
        ex = ref_mod(px);
        ey = ref_mod(py);
        et = ref_mul(px, py);
        @(negedge clk);
        Px = px; Py = py; en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        Px = rand_val(); Py = rand_val();
        for (int i = 1; i <= 255; i++) begin
            @(posedge clk);
            #1;
            en = pulse_en && (i % 40 == 5) && (i < 250);
            if (i == 128 || i == 255) check_all({tag, ".hold"}, prev_x, prev_y, prev_z, prev_t);
        end
        en = 1'b0;
        @(posedge clk);
        #1;
        check_all(tag, ex, ey, 255'd1, et);
        prev_x = ex; prev_y = ey; prev_z = 255'd1; prev_t = et;
    endtask

    initial begin
        logic [N-1:0] a, b, c, d;
        p_val = P512[N-1:0];
        p_m1  = p_val - 255'd1;
        prev_x = '0; prev_y = '0; prev_z = '0; prev_t = '0;
        en = 1'b0; Px = '0; Py = '0;
        rst_n = 1'b1;
        #2;
        check_all("reset", '0, '0, '0, '0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        check_all("idle300", '0, '0, '0, '0);

        run("neutral", 255'd0, 255'd1, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check_all("neutral.stable", 255'd0, 255'd1, 255'd1, 255'd0);

        run("small", 255'd2, 255'd3, 1'b0);
        check("small.const", Rt, 255'd6);
        a = '0; a[254] = 1'b1;
        run("wrap", a, 255'd2, 1'b0);
        check("wrap.const", Rt, 255'd19);
        run("pm1", p_m1, p_m1, 1'b0);
        check("pm1.const", Rt, 255'd1);
        run("unreduced", p_val, 255'd5, 1'b0);
        check("unreduced.const", Rx, 255'd0);

        for (int r = 0; r < 5; r++) run("random", rand_val(), rand_val(), 1'b0);
        run("en_pulse", rand_val(), rand_val(), 1'b1);
        a = '1;
        run("allones", a, rand_val(), 1'b1);

        // en held high: second computation latches on the first IDLE edge after DONE.
        a = rand_val(); b = rand_val(); c = rand_val(); d = rand_val();
        @(negedge clk);
        Px = a; Py = b; en = 1'b1;
        @(posedge clk);
        #1;
        Px = c; Py = d;
        repeat (256) @(posedge clk);
        #1;
        check_all("held.first", ref_mod(a), ref_mod(b), 255'd1, ref_mul(a, b));
        @(posedge clk);
        #1;
        Px = rand_val(); Py = rand_val();
        repeat (255) @(posedge clk);
        #1;
        en = 1'b0;
        check_all("held.hold", ref_mod(a), ref_mod(b), 255'd1, ref_mul(a, b));
        @(posedge clk);
        #1;
        check_all("held.second", ref_mod(c), ref_mod(d), 255'd1, ref_mul(c, d));

        // Reset in the middle of an operation.
        @(negedge clk);
        Px = rand_val(); Py = rand_val(); en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_all("midreset", '0, '0, '0, '0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        check_all("midreset.after", '0, '0, '0, '0);

        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule
